// File: rtl/persiana_motor_drv.sv
// Purpose : half-bridge output stage for the blind motor. Adds interlock, dead-time, soft start and a run timeout.
// Latency : inputs pass a 2-flop synchronizer, so the FSM reacts on the 3rd clk edge after an input change; outputs are registered.
// Backpr. : none. Requests are level-sensitive and sampled every cycle, so nothing is ever queued or dropped.
//
// Ports:
//   clk, reseteo          fast system clock, asynchronous active-high reset
//   subir, bajar          raise/lower requests from the blind FSM (both high = conflict = no request)
//   Ssup, Sinf            upper/lower end-stops, 1 = blind at that limit
//   fault_clr             leaves FAULT, but only while no request is present
//   mot_up, mot_dn        half-bridge enables, never both high
//   duty                  current PWM duty (0 outside the run states)
//   busy, fault           busy = DEAD/RUN_UP/RUN_DN, fault = FAULT
//
// Build option: define PERSIANA_SOFT_START_EN to ramp the duty from 1 up to full scale with PWM on the enables.
// Without it, the duty is loaded at full scale and the enable stays high for the whole run.
module persiana_motor_drv #(
    parameter int DEAD_CYCLES      = 16,
    parameter int RAMP_STEP_CYCLES = 8,
    parameter int PWM_BITS         = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                clk,
    input  logic                reseteo,
    input  logic                subir,
    input  logic                bajar,
    input  logic                Ssup,
    input  logic                Sinf,
    input  logic                fault_clr,
    output logic                mot_up,
    output logic                mot_dn,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy,
    output logic                fault
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int RW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0]       RUN_LAST  = RW'(TIMEOUT_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
`ifdef PERSIANA_SOFT_START_EN
    localparam int SW = $clog2(RAMP_STEP_CYCLES + 1);
    localparam logic [SW-1:0]       RAMP_LAST  = SW'(RAMP_STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_START = PWM_BITS'(1);
`else
    localparam logic [PWM_BITS-1:0] DUTY_START = DUTY_MAX;
`endif

    if (DEAD_CYCLES < 1 || RAMP_STEP_CYCLES < 1 || PWM_BITS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("persiana_motor_drv: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEAD   = 3'd1,
        RUN_UP = 3'd2,
        RUN_DN = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronizers. Bit order: {fault_clr, Sinf, Ssup, bajar, subir}
    // ---------------------------------------------------------------
    logic [4:0] sync_q1, sync_q2;

    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {fault_clr, Sinf, Ssup, bajar, subir};
            sync_q2 <= sync_q1;
        end
    end

    logic s_subir, s_bajar, s_ssup, s_sinf, s_fclr;
    assign s_subir = sync_q2[0];
    assign s_bajar = sync_q2[1];
    assign s_ssup  = sync_q2[2];
    assign s_sinf  = sync_q2[3];
    assign s_fclr  = sync_q2[4];

    logic up_req, dn_req;
    assign up_req = s_subir & ~s_bajar;
    assign dn_req = s_bajar & ~s_subir;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t              state, state_nxt;
    logic                tgt_up, tgt_nxt;     // direction of the pending or current run
    logic [DW-1:0]       dead_cnt, dead_nxt;
    logic [RW-1:0]       run_cnt, run_nxt;
    logic [PWM_BITS-1:0] duty_nxt;
    logic                mot_up_nxt, mot_dn_nxt;
`ifdef PERSIANA_SOFT_START_EN
    logic [SW-1:0]       ramp_cnt, ramp_nxt;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_nxt;
`endif

    // Requests and end-stop seen from the point of view of the current target.
    // In the run states tgt_up still holds the running direction.
    logic own_req, opp_req, own_stop;
    assign own_req  = tgt_up ? up_req : dn_req;
    assign opp_req  = tgt_up ? dn_req : up_req;
    assign own_stop = tgt_up ? s_ssup : s_sinf;

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_up;
        dead_nxt  = '0;
        run_nxt   = '0;
        duty_nxt  = '0;
`ifdef PERSIANA_SOFT_START_EN
        ramp_nxt  = '0;
`endif
        case (state)
            IDLE: begin
                if (up_req && !s_ssup) begin
                    state_nxt = DEAD;
                    tgt_nxt   = 1'b1;
                end else if (dn_req && !s_sinf) begin
                    state_nxt = DEAD;
                    tgt_nxt   = 1'b0;
                end
            end
            DEAD: begin
                if (own_req && !own_stop) begin
                    if (dead_cnt == DEAD_LAST) begin
                        state_nxt = tgt_up ? RUN_UP : RUN_DN;
                        duty_nxt  = DUTY_START;
                    end else begin
                        dead_nxt = dead_cnt + 1'b1;
                    end
                end else if (opp_req) begin
                    // Reversal while still dead: the new direction gets a full dead time.
                    tgt_nxt = ~tgt_up;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN_UP, RUN_DN: begin
                if (own_stop) begin
                    state_nxt = IDLE;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt = FAULT;
                end else if (opp_req) begin
                    state_nxt = DEAD;
                    tgt_nxt   = ~tgt_up;
                end else if (!own_req) begin
                    state_nxt = IDLE;
                end else begin
                    run_nxt = run_cnt + 1'b1;
`ifdef PERSIANA_SOFT_START_EN
                    if (ramp_cnt == RAMP_LAST) begin
                        duty_nxt = (duty == DUTY_MAX) ? duty : duty + 1'b1;
                    end else begin
                        ramp_nxt = ramp_cnt + 1'b1;
                        duty_nxt = duty;
                    end
`else
                    duty_nxt = duty;
`endif
                end
            end
            FAULT: begin
                if (s_fclr && !s_subir && !s_bajar) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Enables are decoded from the next-cycle values and registered, so they
    // change on the same edge as the state and carry no decode glitches.
    // Any state change passes through IDLE or DEAD, where both are low.
`ifdef PERSIANA_SOFT_START_EN
    assign pwm_nxt = pwm_cnt + 1'b1;
    always_comb begin
        mot_up_nxt = (state_nxt == RUN_UP) && (pwm_nxt < duty_nxt);
        mot_dn_nxt = (state_nxt == RUN_DN) && (pwm_nxt < duty_nxt);
    end
`else
    always_comb begin
        mot_up_nxt = (state_nxt == RUN_UP);
        mot_dn_nxt = (state_nxt == RUN_DN);
    end
`endif

    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            state    <= IDLE;
            tgt_up   <= 1'b0;
            dead_cnt <= '0;
            run_cnt  <= '0;
            duty     <= '0;
            mot_up   <= 1'b0;
            mot_dn   <= 1'b0;
`ifdef PERSIANA_SOFT_START_EN
            ramp_cnt <= '0;
            pwm_cnt  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            tgt_up   <= tgt_nxt;
            dead_cnt <= dead_nxt;
            run_cnt  <= run_nxt;
            duty     <= duty_nxt;
            mot_up   <= mot_up_nxt;
            mot_dn   <= mot_dn_nxt;
`ifdef PERSIANA_SOFT_START_EN
            ramp_cnt <= ramp_nxt;
            pwm_cnt  <= pwm_nxt;
`endif
        end
    end

    assign busy  = (state == DEAD) || (state == RUN_UP) || (state == RUN_DN);
    assign fault = (state == FAULT);

endmodule
